// File: rtl/tx_arb_pkg.sv
// Shared definitions for the USB TX arbiter: FSM state encoding, the
// terminator word and the one-hot grant codes.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2,
    TERM = 2'd3
  } arb_state_e;

  localparam logic [8:0] TERM_WORD  = 9'h000;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;
  localparam logic [1:0] GRANT_NONE = 2'b00;

  // One-hot FIFO owner for a given state; the terminator phase owns nothing.
  function automatic logic [1:0] grant_of(input arb_state_e st);
    logic [1:0] g;
    case (st)
      G0:      g = GRANT_S0;
      G1:      g = GRANT_S1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/tx_arb_wdog.sv
// CW-bit up-counter with synchronous clear (priority) and enable, plus a
// terminal-count flag. Used both as the packet length counter and as the
// idle watchdog of the arbiter.
module tx_arb_wdog #(
  parameter int CW = 8,
  parameter int TC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles; clear wins over enable so a counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == CW'(TC));

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin, whole-packet arbiter between the camera packetizer (src0)
// and the SCCB readback stream (src1) in front of the PC-bound FIFO.
// Stalled or over-long packets are closed with a terminator word.
// Optional build macro USB_TX_ARB_STATS_EN adds packet/abort statistics.
import tx_arb_pkg::*;

module usb_tx_arbiter #(
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [8:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  input  logic       fifo_full,
  output logic [8:0] fifo_wdata,
  output logic       fifo_wr,
  output logic [1:0] grant,
  output logic       abort
`ifdef USB_TX_ARB_STATS_EN
  ,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [7:0]  abort_cnt
`endif
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;     // 1: src1 was served last, so src0 wins a tie
  logic       wr_q, wr_d;
  logic [8:0] wdata_q, wdata_d;
  logic       abort_q, abort_d;

  logic       in_grant;
  logic       cur_valid, cur_last;
  logic [8:0] cur_data;
  logic       xfer, term_wr;
  logic       len_tc, wdog_tc;

  // Route the granted source onto a common set of signals.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 9'h000;
    case (state_q)
      G0: begin
        cur_valid = s0_valid;
        cur_last  = s0_last;
        cur_data  = s0_data;
      end
      G1: begin
        cur_valid = s1_valid;
        cur_last  = s1_last;
        cur_data  = s1_data;
      end
      default: begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 9'h000;
      end
    endcase
  end

  assign in_grant = (state_q == G0) || (state_q == G1);
  assign s0_ready = (state_q == G0) && !fifo_full;
  assign s1_ready = (state_q == G1) && !fifo_full;
  assign xfer     = in_grant && cur_valid && !fifo_full;
  assign term_wr  = (state_q == TERM) && !fifo_full;
  assign grant    = grant_of(state_q);

  // Words accepted in the current packet; cleared whenever no packet is open.
  tx_arb_wdog #(.CW(CW), .TC(MAX_PKT - 1)) u_len (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_grant),
    .en_i  (xfer),
    .tc_o  (len_tc)
  );

  // Idle cycles of the owner; full-FIFO stalls with valid high neither count nor clear.
  tx_arb_wdog #(.CW(CW), .TC(TIMEOUT - 1)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_grant || xfer),
    .en_i  (in_grant && !cur_valid),
    .tc_o  (wdog_tc)
  );

  // Next-state and round-robin bookkeeping; last_served only matters in IDLE,
  // so it is recorded as the packet (normal or aborted) leaves its grant state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          state_d = last_q ? G0 : G1;
        end else if (s0_valid) begin
          state_d = G0;
        end else if (s1_valid) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G0, G1: begin
        if (xfer && cur_last) begin
          state_d = IDLE;
          last_d  = (state_q == G1);
        end else if ((xfer && len_tc) || (!xfer && wdog_tc)) begin
          state_d = TERM;
          last_d  = (state_q == G1);
        end else begin
          state_d = state_q;
        end
      end
      TERM: begin
        if (!fifo_full) begin
          state_d = IDLE;
        end else begin
          state_d = TERM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next value of the registered FIFO write port and abort pulse.
  always_comb begin
    wr_d    = xfer || term_wr;
    abort_d = term_wr;
    if (xfer) begin
      wdata_d = cur_data;
    end else if (term_wr) begin
      wdata_d = TERM_WORD;
    end else begin
      wdata_d = wdata_q;
    end
  end

  // State, round-robin pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      wdata_q <= 9'h000;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
    end
  end

  assign fifo_wr    = wr_q;
  assign fifo_wdata = wdata_q;
  assign abort      = abort_q;

`ifdef USB_TX_ARB_STATS_EN
  logic [15:0] pkt0_q, pkt1_q;
  logic [7:0]  abrt_q;

  // Saturating counters of completed packets per source and of aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt0_q <= 16'h0000;
      pkt1_q <= 16'h0000;
      abrt_q <= 8'h00;
    end else begin
      if (xfer && cur_last && (state_q == G0) && (pkt0_q != 16'hFFFF)) begin
        pkt0_q <= pkt0_q + 16'h0001;
      end
      if (xfer && cur_last && (state_q == G1) && (pkt1_q != 16'hFFFF)) begin
        pkt1_q <= pkt1_q + 16'h0001;
      end
      if (term_wr && (abrt_q != 8'hFF)) begin
        abrt_q <= abrt_q + 8'h01;
      end
    end
  end

  assign pkt_cnt0  = pkt0_q;
  assign pkt_cnt1  = pkt1_q;
  assign abort_cnt = abrt_q;
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: a hand-derived vector table,
// directed multi-cycle sequences and a randomized run, all cross-checked
// every cycle against a packet-level reference model.
module tb_usb_tx_arbiter;

  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] s0_data, s1_data;
  logic       s0_valid, s0_last, s1_valid, s1_last;
  logic       s0_ready, s1_ready;
  logic       fifo_full;
  logic [8:0] fifo_wdata;
  logic       fifo_wr;
  logic [1:0] grant;
  logic       abort;
`ifdef USB_TX_ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  abort_cnt;
`endif

  always #5 clk = ~clk;

  usb_tx_arbiter #(.MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s0_data    (s0_data),
    .s0_valid   (s0_valid),
    .s0_last    (s0_last),
    .s0_ready   (s0_ready),
    .s1_data    (s1_data),
    .s1_valid   (s1_valid),
    .s1_last    (s1_last),
    .s1_ready   (s1_ready),
    .fifo_full  (fifo_full),
    .fifo_wdata (fifo_wdata),
    .fifo_wr    (fifo_wr),
    .grant      (grant),
    .abort      (abort)
`ifdef USB_TX_ARB_STATS_EN
    ,
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .abort_cnt  (abort_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the FIFO (-1 nobody), whether a terminator is owed,
  // who wins the next tie, words sent and consecutive idle cycles of the open packet.
  int         m_own, m_prefer, m_len, m_idle;
  bit         m_term;
  logic       e_wr, e_abort;
  logic [8:0] e_data;

  // Bench-side observations.
  logic [8:0] wq[$];
  int         aborts, acc0, acc1;

  typedef struct {
    logic       v0, l0;
    logic [8:0] d0;
    logic       v1, full;
    logic [1:0] g;
    logic       r0, wr;
    logic [8:0] wd;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_prefer = 0; m_len = 0; m_idle = 0; m_term = 1'b0;
    e_wr = 1'b0; e_abort = 1'b0; e_data = 9'h000;
  endtask

  task automatic model_close(input bit term);
    m_prefer = 1 - m_own;
    m_own    = -1;
    m_term   = term;
  endtask

  task automatic model_step();
    logic v, l;
    logic [8:0] d;
    e_wr = 1'b0;
    e_abort = 1'b0;
    if (m_term) begin
      if (!fifo_full) begin
        e_wr = 1'b1; e_data = 9'h000; e_abort = 1'b1; m_term = 1'b0;
      end
    end else if (m_own < 0) begin
      if (s0_valid && s1_valid) m_own = m_prefer;
      else if (s0_valid)        m_own = 0;
      else if (s1_valid)        m_own = 1;
      m_len = 0;
      m_idle = 0;
    end else begin
      v = (m_own == 1) ? s1_valid : s0_valid;
      l = (m_own == 1) ? s1_last  : s0_last;
      d = (m_own == 1) ? s1_data  : s0_data;
      if (v && !fifo_full) begin
        e_wr = 1'b1; e_data = d; m_len++; m_idle = 0;
        if (l)                   model_close(1'b0);
        else if (m_len == MAX_PKT) model_close(1'b1);
      end else if (m_idle == TIMEOUT - 1) begin
        model_close(1'b1);
      end else if (!v) begin
        m_idle++;
      end
    end
  endtask

  task automatic check_cycle();
    logic [1:0] eg;
    eg = m_term ? 2'b00 : (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    check("cycle",
          32'({grant, s0_ready, s1_ready, fifo_wr, abort, fifo_wr ? fifo_wdata : 9'h000}),
          32'({eg, (!m_term && m_own == 0 && !fifo_full), (!m_term && m_own == 1 && !fifo_full),
               e_wr, e_abort, e_wr ? e_data : 9'h000}));
  endtask

  // One clock: inputs were set at the negedge; compare, observe, advance model.
  task automatic tick();
    #1;
    check_cycle();
    if (fifo_wr) wq.push_back(fifo_wdata);
    if (abort) aborts++;
    if (s0_valid && s0_ready) acc0++;
    if (s1_valid && s1_ready) acc1++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = 9'h000;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = 9'h000;
    fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_outs", 32'({grant, s0_ready, s1_ready, fifo_wr, fifo_wdata, abort}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wq.delete();
    aborts = 0; acc0 = 0; acc1 = 0;
  endtask

  initial begin
    logic [1:0] seq[$];
    logic [1:0] prev_g;
    logic [8:0] words[8];
    int idle_g, stuck, cyc;

    tbl[0] = '{1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'h000};
    tbl[1] = '{1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 9'h000};
    tbl[2] = '{1'b1, 1'b0, 9'h1AA, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h1FF};
    tbl[3] = '{1'b1, 1'b0, 9'h1BB, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h1AA};
    tbl[4] = '{1'b1, 1'b1, 9'h1CC, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h1BB};
    tbl[5] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 9'h1CC};
    tbl[6] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'h000};

    do_reset();
`ifdef USB_TX_ARB_STATS_EN
    check("stats_reset", 32'({pkt_cnt0, pkt_cnt1, abort_cnt}), 32'd0);
`endif

    // 1: single 4-word src0 packet from the table.
    for (int i = 0; i < 7; i++) begin
      s0_valid = tbl[i].v0; s0_last = tbl[i].l0; s0_data = tbl[i].d0;
      s1_valid = tbl[i].v1; fifo_full = tbl[i].full;
      #1;
      check("tbl", 32'({grant, s0_ready, s1_ready, fifo_wr, fifo_wr ? fifo_wdata : 9'h000}),
            32'({tbl[i].g, tbl[i].r0, 1'b0, tbl[i].wr, tbl[i].wd}));
      tick();
    end

    // 2: both sources valid from reset; 3-word packets alternate src0, src1, src0.
    do_reset();
    prev_g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      s0_valid = 1'b1; s0_last = (acc0 % 3 == 2); s0_data = 9'($urandom);
      s1_valid = 1'b1; s1_last = (acc1 % 3 == 2); s1_data = 9'($urandom);
      if (grant != 2'b00 && prev_g == 2'b00) seq.push_back(grant);
      prev_g = grant;
      tick();
    end
    if (seq.size() < 3) check("rr_episodes", 32'(seq.size()), 32'd3);
    else check("rr_order", 32'({seq[0], seq[1], seq[2]}), 32'({2'b01, 2'b10, 2'b01}));

    // 3: fifo_full held 10 cycles mid-packet; nothing lost or duplicated.
    do_reset();
    for (int i = 0; i < 8; i++) words[i] = 9'($urandom);
    stuck = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      s0_valid = (acc0 < 8);
      s0_data  = words[acc0 % 8];
      s0_last  = (acc0 == 7);
      fifo_full = (cyc >= 3 && cyc < 13);
      #1;
      if (fifo_full && s0_ready) stuck++;
      tick();
    end
    check("full_ready", 32'(stuck), 32'd0);
    check("full_count", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8 && i < wq.size(); i++) check("full_word", 32'(wq[i]), 32'(words[i]));
    check("full_abort", 32'(aborts), 32'd0);

    // 4: src1 stops after 2 words; watchdog closes the packet.
    do_reset();
    idle_g = 0;
    for (cyc = 0; cyc < 400 && aborts == 0; cyc++) begin
      s1_valid = (acc1 < 2); s1_data = 9'h155 + 9'(acc1); s1_last = 1'b0;
      if (grant == 2'b10 && !s1_valid) idle_g++;
      tick();
    end
    check("wdog_fired", 32'(aborts), 32'd1);
    check("wdog_idle", 32'(idle_g), 32'(TIMEOUT));
    check("wdog_words", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) check("wdog_data", 32'({wq[0], wq[1], wq[2]}), 32'({9'h155, 9'h156, 9'h000}));
    tick();
    check("wdog_abort_once", 32'(aborts), 32'd1);

    // 5: 70 words without last; 64 go out, then the terminator, then the next grant.
    do_reset();
    for (cyc = 0; cyc < 200 && wq.size() < 67; cyc++) begin
      s0_valid = 1'b1; s0_last = 1'b0; s0_data = 9'h100 | 9'(acc0);
      tick();
    end
    check("len_count", 32'(wq.size()), 32'd67);
    for (int i = 0; i < 64 && i < wq.size(); i++) check("len_word", 32'(wq[i]), 32'(9'h100 | 9'(i)));
    if (wq.size() >= 66) check("len_term", 32'({wq[64], wq[65]}), 32'({9'h000, 9'h140}));
    check("len_abort", 32'(aborts), 32'd1);
`ifdef USB_TX_ARB_STATS_EN
    check("stats_abort", 32'(abort_cnt), 32'd1);
`endif

    // 6: asynchronous reset in the middle of the second packet.
    check("pre_rst_wr", 32'(fifo_wr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'({grant, s0_ready, s1_ready, fifo_wr, fifo_wdata, abort}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; s0_last = 1'b0; s1_last = 1'b0;
    tick();
    check("tie_after_rst", 32'(grant), 32'(2'b01));
`ifdef USB_TX_ARB_STATS_EN
    check("stats_after_rst", 32'({pkt_cnt0, pkt_cnt1, abort_cnt}), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (cyc = 0; cyc < 3000; cyc++) begin
      s0_valid  = ($urandom_range(3) != 0);
      s0_last   = ($urandom_range(7) == 0);
      s0_data   = 9'($urandom);
      s1_valid  = ($urandom_range(3) != 0);
      s1_last   = ($urandom_range(7) == 0);
      s1_data   = 9'($urandom);
      fifo_full = ($urandom_range(3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
